data_l_capture: RTL and testbench
=================================

DATA_L_CAPTURE -- requirements
Module: data_l_capture

Interface
REQ-001 SHALL have parameter DATA_BITS, default 24: serial word length, legal range 8..24.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-003 SHALL have port clk, input, 1: system clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sclk_in, input, 1: external serial clock, asynchronous to clk; data valid on its rising edge.
REQ-006 SHALL have port sdata_in, input, 1: external serial data, MSB first.
REQ-007 SHALL have port frame_n, input, 1: active-low frame enclosing one word.
REQ-008 SHALL have port data_out, output, 32: word presented to the PIO input port, {abort[31], seq[30:24], sample[23:0]}.
REQ-009 SHALL have port word_valid, output, 1: one-clk pulse on each data_out update with a completed word.

Function
REQ-010 SHALL pass sclk_in, sdata_in and frame_n each through SYNC_STAGES flops; all logic uses synchronized copies only.
REQ-011 SHALL detect an sclk rise as synchronized sclk = 1 with its one-cycle-delayed copy = 0.
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE -> SHIFT SHALL occur only on a synchronized frame_n high-to-low transition; clears bit counter.
REQ-014 In SHIFT, each sclk rise SHALL shift synchronized sdata into the LSB of the shift register and increment the bit counter.
REQ-015 On the sclk rise carrying bit DATA_BITS, on that same clk edge: sample field SHALL load the completed word (right-justified, bits above DATA_BITS zero), seq SHALL increment modulo 128 (127 -> 0), abort SHALL clear, word_valid SHALL pulse, state -> DONE.
REQ-016 Pin-to-data_out latency SHALL be SYNC_STAGES+1 clk cycles after the final sclk_in rising edge.
REQ-017 In DONE, further sclk rises SHALL be ignored; synchronized frame_n high -> IDLE.
REQ-018 In SHIFT, synchronized frame_n high before bit DATA_BITS SHALL: set abort, leave sample and seq unchanged, no word_valid, state -> IDLE.
REQ-019 Final sclk rise and frame_n high in the same clk cycle SHALL complete the word (edge wins), then IDLE on next cycle.
REQ-020 data_out SHALL hold its value between updates; abort SHALL change only per REQ-015/REQ-018.
REQ-021 Input constraint: sclk_in high and low phases each >= SYNC_STAGES+1 clk periods; faster sclk is unsupported.

Reset
REQ-022 reset_n low SHALL force state IDLE, bit counter 0, shift register 0, data_out 0, word_valid 0 immediately.
REQ-023 sclk/sdata synchronizers SHALL reset to 0; frame_n synchronizers SHALL reset to 0 (asserted), so a frame already in progress at reset release is ignored until frame_n is seen high.
REQ-024 Reset asserted mid-frame SHALL discard partial data without setting abort.

Structure
REQ-025 Package data_l_capture_pkg SHALL hold the FSM state enum, SEQ_W = 7, DATA_OUT_W = 32, and field bit positions of data_out.
REQ-026 One sub-module bit_sync (parameters STAGES, RESET_VAL; 1-bit in/out) SHALL be instantiated three times for REQ-010.

Verification
REQ-027 24-bit frame 0xA5C3F0, sclk = clk/8 -> data_out = 0x01A5C3F0, one word_valid pulse, latency SYNC_STAGES+1 after last edge.
REQ-028 frame_n released after 10 bits -> data_out[31] = 1, data_out[30:0] unchanged, no word_valid; next good frame 0x000001 -> data_out = 0x02000001.
REQ-029 129 back-to-back good frames -> seq wraps 127 -> 0, final data_out[30:24] = 0x01.
REQ-030 Reset pulse after 12 bits, frame_n held low through release, then 12 more edges -> no word_valid; next full frame captured correctly with seq = 1.
REQ-031 DATA_BITS = 8, frame 0xFF plus 4 extra sclk edges before frame_n high -> data_out = 0x010000FF, extra edges ignored.
REQ-032 Final sclk rise and frame_n rise in same synchronized cycle -> word completes, abort = 0.

Source files
------------

// File: rtl/data_l_capture_pkg.sv
// data_l_capture_pkg
// Shared definitions for the serial word capture block: FSM state encoding,
// field widths and the bit positions of the 32-bit word handed to the PIO port.
package data_l_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SEQ_W      = 7;
    localparam int DATA_OUT_W = 32;
    localparam int SAMPLE_W   = 24;

    localparam int ABORT_BIT  = 31;
    localparam int SEQ_LSB    = 24;
    localparam int SEQ_MSB    = SEQ_LSB + SEQ_W - 1;
    localparam int SAMPLE_LSB = 0;
    localparam int SAMPLE_MSB = SAMPLE_LSB + SAMPLE_W - 1;

endpackage

// File: rtl/data_l_capture_bit_sync.sv
// bit_sync
// Multi-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset; all stages load RESET_VAL
//   d        - asynchronous input
//   q        - synchronized output (STAGES clk cycles of latency)
module bit_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/data_l_capture.sv
// data_l_capture
// Captures one MSB-first serial word per frame from an external serial
// clock domain and presents it, with a sequence number and abort flag,
// as a 32-bit word for a PIO input port.
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   sclk_in    - external serial clock (async), data valid on its rise
//   sdata_in   - external serial data (async), MSB first
//   frame_n    - active-low frame enclosing one word (async)
//   data_out   - {abort, seq[6:0], sample[23:0]}
//   word_valid - one-clk pulse when data_out carries a newly completed word
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a frame_n high-to-low transition
// SHIFT   | shifting one bit per sclk rise until DATA_BITS collected
// DONE    | word delivered; ignoring sclk until frame_n goes high
module data_l_capture
    import data_l_capture_pkg::*;
#(
    parameter int DATA_BITS   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk_in,
    input  logic                  sdata_in,
    input  logic                  frame_n,
    output logic [DATA_OUT_W-1:0] data_out,
    output logic                  word_valid
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic sclk_s;
    logic sdata_s;
    logic frame_s;
    logic sclk_d;
    logic frame_d;
    logic sclk_rise;
    logic frame_fall;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       bit_cnt, cnt_next;
    logic [DATA_BITS-1:0]   shift_r, shift_next;
    logic [SAMPLE_W-1:0]    sample_r, sample_next;
    logic [SEQ_W-1:0]       seq_r, seq_next;
    logic                   abort_r, abort_next;
    logic                   valid_next;

    bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sclk_in),
        .q       (sclk_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdata (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sdata_in),
        .q       (sdata_s)
    );

    // frame_n resets to the asserted level so a frame already running at
    // reset release cannot produce a falling edge until it is seen high.
    bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_frame (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (frame_n),
        .q       (frame_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_d  <= 1'b0;
            frame_d <= 1'b0;
        end else begin
            sclk_d  <= sclk_s;
            frame_d <= frame_s;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_d;
    assign frame_fall = frame_d & ~frame_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_r    <= '0;
            sample_r   <= '0;
            seq_r      <= '0;
            abort_r    <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= cnt_next;
            shift_r    <= shift_next;
            sample_r   <= sample_next;
            seq_r      <= seq_next;
            abort_r    <= abort_next;
            word_valid <= valid_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = bit_cnt;
        shift_next  = shift_r;
        sample_next = sample_r;
        seq_next    = seq_r;
        abort_next  = abort_r;
        valid_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (frame_fall) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            ST_SHIFT: begin
                // An sclk rise takes priority over frame release, so the
                // final bit arriving together with frame_n high still lands.
                if (sclk_rise) begin
                    shift_next = {shift_r[DATA_BITS-2:0], sdata_s};
                    cnt_next   = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        sample_next = SAMPLE_W'(shift_next);
                        seq_next    = seq_r + 1'b1;
                        abort_next  = 1'b0;
                        valid_next  = 1'b1;
                        state_next  = ST_DONE;
                    end
                end else if (frame_s) begin
                    abort_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (frame_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_out                        = '0;
        data_out[ABORT_BIT]             = abort_r;
        data_out[SEQ_MSB:SEQ_LSB]       = seq_r;
        data_out[SAMPLE_MSB:SAMPLE_LSB] = sample_r;
    end

endmodule

// File: tb/tb_data_l_capture.sv
module tb_data_l_capture;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b0;
    logic        sdata = 1'b0;
    logic        frame_n24 = 1'b1;
    logic        frame_n8 = 1'b1;
    logic [31:0] dout24;
    logic [31:0] dout8;
    logic        wv24;
    logic        wv8;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_l_capture #(.DATA_BITS(24), .SYNC_STAGES(SYNC)) u_dut24 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sclk_in    (sclk),
        .sdata_in   (sdata),
        .frame_n    (frame_n24),
        .data_out   (dout24),
        .word_valid (wv24)
    );

    data_l_capture #(.DATA_BITS(8), .SYNC_STAGES(SYNC)) u_dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sclk_in    (sclk),
        .sdata_in   (sdata),
        .frame_n    (frame_n8),
        .data_out   (dout8),
        .word_valid (wv8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vcnt24 = 0, vcnt8 = 0, vcyc24 = 0, vcyc8 = 0;
    always @(negedge clk) begin
        if (wv24) begin vcnt24++; vcyc24 = cyc; end
        if (wv8)  begin vcnt8++;  vcyc8  = cyc; end
    end

    // Reference model: per instance, words completed / abort flag / last sample.
    int m_seq[2];
    int m_abort[2];
    int m_sample[2];
    int last_rise = 0;

    function automatic logic [31:0] expected(input int inst);
        logic [6:0]  s;
        logic [23:0] d;
        s = 7'(m_seq[inst] % 128);
        d = 24'(m_sample[inst]);
        return {(m_abort[inst] != 0), s, d};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_seq[k] = 0; m_abort[k] = 0; m_sample[k] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input int inst, input logic v);
        if (inst == 0) frame_n24 = v;
        else           frame_n8  = v;
    endtask

    // One serial bit at sclk = clk/8; caller is positioned at a negedge.
    task automatic send_bit(input logic b, input bit raise, input int inst);
        sclk  = 1'b0;
        sdata = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        last_rise = cyc;
        if (raise) set_frame(inst, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input int inst, input logic [23:0] w, input int nbits,
                             input bit same, input string tag);
        int          db;
        int          v0;
        int          vnow;
        int          vcnow;
        int          rise;
        bit          complete;
        logic        b;
        logic [31:0] obs;
        db = (inst == 0) ? 24 : 8;
        v0 = (inst == 0) ? vcnt24 : vcnt8;
        complete = (nbits >= db);
        rise = 0;
        set_frame(inst, 1'b0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = (i < db) ? w[db-1-i] : logic'($urandom_range(0, 1));
            send_bit(b, same && (i == nbits - 1), inst);
            if (i == db - 1) rise = last_rise;
        end
        set_frame(inst, 1'b1);
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        if (complete) begin
            m_seq[inst]    = (m_seq[inst] + 1) % 128;
            m_abort[inst]  = 0;
            m_sample[inst] = int'(w) & ((db == 24) ? 32'h00FF_FFFF : 32'h0000_00FF);
        end else begin
            m_abort[inst] = 1;
        end
        obs   = (inst == 0) ? dout24 : dout8;
        vnow  = (inst == 0) ? vcnt24 : vcnt8;
        vcnow = (inst == 0) ? vcyc24 : vcyc8;
        check({tag, " data"}, obs, expected(inst));
        check({tag, " pulses"}, 32'(vnow - v0), complete ? 32'd1 : 32'd0);
        if (complete) check({tag, " latency"}, 32'(vcnow - rise), 32'(SYNC + 1));
    endtask

    initial begin
        logic [23:0] w;
        int          nb;
        int          v0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset dout24", dout24, 32'h0);
        check("reset valid24", {31'h0, wv24}, 32'h0);
        check("reset dout8", dout8, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post-reset dout24", dout24, 32'h0);

        run_frame(0, 24'hA5C3F0, 24, 1'b0, "basic");
        check("basic value", dout24, 32'h01A5C3F0);

        run_frame(0, 24'h123456, 10, 1'b0, "abort");
        check("abort value", dout24, 32'h81A5C3F0);
        run_frame(0, 24'h000001, 24, 1'b0, "after_abort");
        check("after_abort value", dout24, 32'h02000001);

        for (int k = 0; k < 6; k++) begin
            w  = 24'($urandom);
            nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 23))
                                             : 24 + int'($urandom_range(0, 3));
            run_frame(0, w, nb, 1'b0, "random");
        end

        // Reset in the middle of a frame, frame_n held low through release.
        set_frame(0, 1'b0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 12; i++) send_bit(logic'($urandom_range(0, 1)), 1'b0, 0);
        reset_n = 1'b0;
        #1;
        check("mid-reset dout24", dout24, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        v0 = vcnt24;
        for (int i = 0; i < 12; i++) send_bit(logic'($urandom_range(0, 1)), 1'b0, 0);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        check("held-frame pulses", 32'(vcnt24 - v0), 32'd0);
        check("held-frame dout24", dout24, 32'h0);
        set_frame(0, 1'b1);
        repeat (8) @(negedge clk);
        run_frame(0, 24'($urandom), 24, 1'b0, "post_reset");
        check("post_reset seq", {25'h0, dout24[30:24]}, 32'd1);

        run_frame(0, 24'($urandom), 24, 1'b1, "same_edge");
        check("same_edge abort", {31'h0, dout24[31]}, 32'h0);
        run_frame(0, 24'($urandom), 24, 1'b0, "post_same");

        run_frame(1, 24'h0000FF, 12, 1'b0, "db8_extra");
        check("db8 value", dout8, 32'h010000FF);
        run_frame(1, 24'($urandom), 5, 1'b0, "db8_abort");
        run_frame(1, 24'($urandom), 8, 1'b0, "db8_random");

        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 129; k++) begin
            run_frame(0, 24'($urandom), 24, 1'b0, "wrap");
            if (k == 127) check("wrap to zero", {25'h0, dout24[30:24]}, 32'd0);
        end
        check("wrap final seq", {25'h0, dout24[30:24]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
